data_mem_v2: RTL and testbench

Parametrised byte-addressable data memory for the single-cycle/pipelined CPU datapath, replacing the fixed 256-byte word-only memory. It supports byte, halfword and word accesses with optional sign extension, and a valid/ready request port. It has a configurable read pipeline latency, alignment and range error reporting, and a hardware zero-fill sweep after reset. Storage is big-endian: byte at address A holds bits [31:24] of the word at A.

---
 rtl/data_mem_v2.sv | 167 ++++++++++++++++
 tb/tb_data_mem_v2.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_v2.sv
// Byte-addressable big-endian data memory with byte/half/word access, a
// READ_LAT-deep response pipeline and a zero-fill sweep after reset.
module data_mem_v2 #(
  parameter int ADDR_W   = 8,
  parameter int READ_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int CW    = ADDR_W - 2;
  localparam int L     = READ_LAT - 1;

  // Handshake: a request is accepted on a rising edge where req_valid && req_ready;
  // nothing is held or queued when req_ready is low, and responses cannot be stalled.

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            clr_we;
  logic [7:0]      mem [DEPTH];

  logic            acc, err;
  logic [ADDR_W-1:0] a0, a1, a2, a3;
  logic [31:0]     ld_data;

  logic            p_v  [READ_LAT];
  logic            p_e  [READ_LAT];
  logic [1:0]      p_sz [READ_LAT];
  logic            p_sg [READ_LAT];
  logic [31:0]     p_d  [READ_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      CLEAR: begin
        if (cnt == {CW{1'b1}}) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      RUN:     state_nxt = RUN;
      default: state_nxt = CLEAR;
    endcase
  end

  always_comb begin
    req_ready = (state == RUN);
    clr_we    = (state == CLEAR);
  end

  assign acc = req_valid && req_ready;
  assign a0  = req_addr[ADDR_W-1:0];
  // OR-ing the low bits keeps every byte index inside the aligned group, so no wrap.
  assign a1  = a0 | ADDR_W'(1);
  assign a2  = a0 | ADDR_W'(2);
  assign a3  = a0 | ADDR_W'(3);

  always_comb begin
    err = 1'b0;
    if (req_size == 2'b11)                     err = 1'b1;
    if (req_size == 2'b01 && a0[0])            err = 1'b1;
    if (req_size == 2'b10 && (|a0[1:0]))       err = 1'b1;
    if (|(req_addr >> ADDR_W))                 err = 1'b1;
  end

  always_comb begin
    ld_data = '0;
    if (!req_we && !err) begin
      case (req_size)
        2'b00:   ld_data = {24'b0, mem[a0]};
        2'b01:   ld_data = {16'b0, mem[a0], mem[a1]};
        2'b10:   ld_data = {mem[a0], mem[a1], mem[a2], mem[a3]};
        default: ld_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[{cnt, 2'b00}] <= '0;
      mem[{cnt, 2'b01}] <= '0;
      mem[{cnt, 2'b10}] <= '0;
      mem[{cnt, 2'b11}] <= '0;
    end else if (acc && req_we && !err) begin
      case (req_size)
        2'b00: mem[a0] <= req_wdata[7:0];
        2'b01: begin
          mem[a0] <= req_wdata[15:8];
          mem[a1] <= req_wdata[7:0];
        end
        2'b10: begin
          mem[a0] <= req_wdata[31:24];
          mem[a1] <= req_wdata[23:16];
          mem[a2] <= req_wdata[15:8];
          mem[a3] <= req_wdata[7:0];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < READ_LAT; i++) begin
        p_v[i]  <= 1'b0;
        p_e[i]  <= 1'b0;
        p_sz[i] <= 2'b00;
        p_sg[i] <= 1'b0;
        p_d[i]  <= '0;
      end
    end else begin
      p_v[0]  <= acc;
      p_e[0]  <= acc && err;
      p_sz[0] <= req_size;
      p_sg[0] <= req_signed;
      p_d[0]  <= acc ? ld_data : '0;
      for (int i = 1; i < READ_LAT; i++) begin
        p_v[i]  <= p_v[i-1];
        p_e[i]  <= p_e[i-1];
        p_sz[i] <= p_sz[i-1];
        p_sg[i] <= p_sg[i-1];
        p_d[i]  <= p_d[i-1];
      end
    end
  end

  // Extension happens here so the pipeline carries raw right-aligned bytes.
  always_comb begin
    rsp_valid = p_v[L];
    rsp_err   = p_v[L] && p_e[L];
    rsp_rdata = '0;
    if (p_v[L] && !p_e[L]) begin
      case (p_sz[L])
        2'b00:   rsp_rdata = {{24{p_sg[L] & p_d[L][7]}}, p_d[L][7:0]};
        2'b01:   rsp_rdata = {{16{p_sg[L] & p_d[L][15]}}, p_d[L][15:0]};
        2'b10:   rsp_rdata = p_d[L];
        default: rsp_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_v2.sv
// Directed bench for data_mem_v2: one READ_LAT=1 and one READ_LAT=3 instance
// driven with identical requests, so both hold the same memory image.
module tb_data_mem_v2;
  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        r1_ready, r1_valid, r1_err;
  logic [31:0] r1_rdata;
  logic        r3_ready, r3_valid, r3_err;
  logic [31:0] r3_rdata;

  int total = 0;
  int bad   = 0;

  logic        b_we   [8];
  logic [1:0]  b_size [8];
  logic        b_sgn  [8];
  logic [31:0] b_addr [8];
  logic [31:0] b_wd   [8];
  logic [31:0] b_exp  [8];
  logic        b_err  [8];

  data_mem_v2 #(.ADDR_W(8), .READ_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(r1_ready),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(r1_valid), .rsp_rdata(r1_rdata), .rsp_err(r1_err)
  );

  data_mem_v2 #(.ADDR_W(8), .READ_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(r3_ready),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(r3_valid), .rsp_rdata(r3_rdata), .rsp_err(r3_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Single request, checked on both instances; entered and left on a falling edge.
  task automatic do_req(input string tag, input logic we, input logic [1:0] sz,
                        input logic sg, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_d, input logic exp_e);
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
    req_addr = addr; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    chk({tag, "_v1"}, 32'(r1_valid), 32'd1);
    chk({tag, "_d1"}, r1_rdata, exp_d);
    chk({tag, "_e1"}, 32'(r1_err), 32'(exp_e));
    chk({tag, "_v3early"}, 32'(r3_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_v1drop"}, 32'(r1_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_v3"}, 32'(r3_valid), 32'd1);
    chk({tag, "_d3"}, r3_rdata, exp_d);
    chk({tag, "_e3"}, 32'(r3_err), 32'(exp_e));
  endtask

  // Back-to-back requests from the b_* table; the LAT=3 instance answers two falling edges later.
  task automatic burst(input string tag, input int n);
    int idx;
    for (int c = 0; c < n + 4; c++) begin
      if (c < n) begin
        req_valid = 1'b1; req_we = b_we[c]; req_size = b_size[c];
        req_signed = b_sgn[c]; req_addr = b_addr[c]; req_wdata = b_wd[c];
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
      if (c < n) begin
        chk($sformatf("%s_v1_%0d", tag, c), 32'(r1_valid), 32'd1);
        chk($sformatf("%s_d1_%0d", tag, c), r1_rdata, b_exp[c]);
      end else begin
        chk($sformatf("%s_v1_%0d", tag, c), 32'(r1_valid), 32'd0);
      end
      idx = c - 2;
      if (idx >= 0 && idx < n) begin
        chk($sformatf("%s_v3_%0d", tag, c), 32'(r3_valid), 32'd1);
        chk($sformatf("%s_d3_%0d", tag, c), r3_rdata, b_exp[idx]);
        chk($sformatf("%s_e3_%0d", tag, c), 32'(r3_err), 32'(b_err[idx]));
      end else begin
        chk($sformatf("%s_v3_%0d", tag, c), 32'(r3_valid), 32'd0);
        chk($sformatf("%s_d3_%0d", tag, c), r3_rdata, 32'd0);
      end
    end
    req_valid = 1'b0;
  endtask

  initial begin
    int cyc;
    logic seen;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_valid1", 32'(r1_valid), 32'd0);
    chk("rst_rdata1", r1_rdata, 32'd0);
    chk("rst_err1",   32'(r1_err), 32'd0);
    chk("rst_ready1", 32'(r1_ready), 32'd0);
    chk("rst_valid3", 32'(r3_valid), 32'd0);
    chk("rst_ready3", 32'(r3_ready), 32'd0);

    // clear sweep: 64 rising edges after rst falls
    rst = 1'b0;
    cyc = 0;
    while (!r1_ready && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("clear_len", 32'(cyc), 32'd64);
    chk("clear_ready3", 32'(r3_ready), 32'd1);

    do_req("ld_fc", 1'b0, 2'b10, 1'b0, 32'h0000_00FC, 32'h0, 32'h0000_0000, 1'b0);

    // endianness
    do_req("st_w10", 1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344, 32'h0, 1'b0);
    do_req("ld_b10", 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 32'h0000_0011, 1'b0);
    do_req("ld_b11", 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 32'h0000_0022, 1'b0);
    do_req("ld_b12", 1'b0, 2'b00, 1'b0, 32'h12, 32'h0, 32'h0000_0033, 1'b0);
    do_req("ld_b13", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'h0000_0044, 1'b0);
    do_req("ld_h12", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'h0000_3344, 1'b0);

    // sign extension
    do_req("st_b21",  1'b1, 2'b00, 1'b0, 32'h21, 32'hFFFF_FF80, 32'h0, 1'b0);
    do_req("ld_sb21", 1'b0, 2'b00, 1'b1, 32'h21, 32'h0, 32'hFFFF_FF80, 1'b0);
    do_req("ld_ub21", 1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 32'h0000_0080, 1'b0);
    do_req("st_h22",  1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_FFFE, 32'h0, 1'b0);
    do_req("ld_sh22", 1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 32'hFFFF_FFFE, 1'b0);
    do_req("ld_uh22", 1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 32'h0000_FFFE, 1'b0);
    do_req("ld_w20",  1'b0, 2'b10, 1'b1, 32'h20, 32'h0, 32'h0080_FFFE, 1'b0);

    // errors and boundaries
    do_req("st_w00",   1'b1, 2'b10, 1'b0, 32'h00, 32'hA1B2_C3D4, 32'h0, 1'b0);
    do_req("err_ldw2", 1'b0, 2'b10, 1'b0, 32'h02, 32'h0, 32'h0, 1'b1);
    do_req("err_ldh5", 1'b0, 2'b01, 1'b1, 32'h05, 32'h0, 32'h0, 1'b1);
    do_req("err_sz3",  1'b0, 2'b11, 1'b0, 32'h00, 32'h0, 32'h0, 1'b1);
    do_req("err_w100", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1);
    do_req("err_stw2", 1'b1, 2'b10, 1'b0, 32'h02, 32'hDEAD_BEEF, 32'h0, 1'b1);
    do_req("err_stb100", 1'b1, 2'b00, 1'b0, 32'h100, 32'h0000_0055, 32'h0, 1'b1);
    do_req("err_sthi", 1'b1, 2'b10, 1'b0, 32'h8000_0000, 32'h1234_5678, 32'h0, 1'b1);
    do_req("ld_w00",   1'b0, 2'b10, 1'b0, 32'h00, 32'h0, 32'hA1B2_C3D4, 1'b0);
    do_req("ld_h04",   1'b0, 2'b01, 1'b0, 32'h04, 32'h0, 32'h0000_0000, 1'b0);
    do_req("st_wfc",   1'b1, 2'b10, 1'b0, 32'hFC, 32'hCAFE_F00D, 32'h0, 1'b0);
    do_req("ld_wfc",   1'b0, 2'b10, 1'b0, 32'hFC, 32'h0, 32'hCAFE_F00D, 1'b0);
    do_req("ld_w00b",  1'b0, 2'b10, 1'b0, 32'h00, 32'h0, 32'hA1B2_C3D4, 1'b0);

    // four back-to-back loads
    b_we[0] = 1'b0; b_size[0] = 2'b10; b_sgn[0] = 1'b0; b_addr[0] = 32'h10; b_wd[0] = '0; b_exp[0] = 32'h1122_3344; b_err[0] = 1'b0;
    b_we[1] = 1'b0; b_size[1] = 2'b00; b_sgn[1] = 1'b0; b_addr[1] = 32'h13; b_wd[1] = '0; b_exp[1] = 32'h0000_0044; b_err[1] = 1'b0;
    b_we[2] = 1'b0; b_size[2] = 2'b01; b_sgn[2] = 1'b1; b_addr[2] = 32'h22; b_wd[2] = '0; b_exp[2] = 32'hFFFF_FFFE; b_err[2] = 1'b0;
    b_we[3] = 1'b0; b_size[3] = 2'b10; b_sgn[3] = 1'b0; b_addr[3] = 32'hFC; b_wd[3] = '0; b_exp[3] = 32'hCAFE_F00D; b_err[3] = 1'b0;
    burst("b2b", 4);

    // store then immediate load of the same word, then a misaligned error in the stream
    b_we[0] = 1'b1; b_size[0] = 2'b10; b_sgn[0] = 1'b0; b_addr[0] = 32'h40; b_wd[0] = 32'h5A5A_0F0F; b_exp[0] = 32'h0; b_err[0] = 1'b0;
    b_we[1] = 1'b0; b_size[1] = 2'b10; b_sgn[1] = 1'b0; b_addr[1] = 32'h40; b_wd[1] = '0; b_exp[1] = 32'h5A5A_0F0F; b_err[1] = 1'b0;
    b_we[2] = 1'b0; b_size[2] = 2'b01; b_sgn[2] = 1'b0; b_addr[2] = 32'h41; b_wd[2] = '0; b_exp[2] = 32'h0; b_err[2] = 1'b1;
    burst("st_ld", 3);

    // reset with two loads in flight
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h10;
    @(negedge clk);
    req_addr = 32'h20;
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | r1_valid | r3_valid;
    end
    chk("mid_rst_norsp", 32'(seen), 32'd0);
    chk("mid_rst_ready1", 32'(r1_ready), 32'd0);
    chk("mid_rst_ready3", 32'(r3_ready), 32'd0);

    // requests presented during the sweep must be ignored
    rst = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h10; req_wdata = 32'h7777_7777;
    cyc = 0;
    while (!r1_ready && cyc < 200) begin
      @(negedge clk);
      seen = seen | r1_valid | r3_valid;
      cyc++;
    end
    req_valid = 1'b0;
    chk("reclear_len", 32'(cyc), 32'd64);
    chk("reclear_norsp", 32'(seen), 32'd0);
    chk("reclear_ready3", 32'(r3_ready), 32'd1);
    do_req("ld_w10_zero", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h0000_0000, 1'b0);
    do_req("ld_wfc_zero", 1'b0, 2'b10, 1'b0, 32'hFC, 32'h0, 32'h0000_0000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
